// File: rtl/mips_exec_if.sv
// Operand, control and result bundle of the MIPS execute stage.
// The master drives operands and control; the slave returns results.
interface mips_exec_if;
  logic        clk_enable;
  logic [1:0]  alu_op;
  logic [5:0]  opcode;
  logic [5:0]  function_code;
  logic [4:0]  shamt;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] branch_addr;
  logic [31:0] jump_addr;
  logic [31:0] pc_plus4;
  logic        condition_met;
  logic        jump1;
  logic        jump2;
  logic [4:0]  alu_ctrl;
  logic [31:0] alu_out;
  logic        zero;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] tgt_addr_0;
  logic [31:0] tgt_addr_1;

  modport master (
    output clk_enable, alu_op, opcode, function_code, shamt, a, b,
           branch_addr, jump_addr, pc_plus4, condition_met, jump1, jump2,
    input  alu_ctrl, alu_out, zero, hi, lo, tgt_addr_0, tgt_addr_1
  );

  modport slave (
    input  clk_enable, alu_op, opcode, function_code, shamt, a, b,
           branch_addr, jump_addr, pc_plus4, condition_met, jump1, jump2,
    output alu_ctrl, alu_out, zero, hi, lo, tgt_addr_0, tgt_addr_1
  );
endinterface

// File: rtl/mips_exec_unit.sv
// Execute-stage slice: ALU control decode, 32-bit ALU with mult/div,
// and next-PC target selection with a delay-slot target register.
module mips_exec_unit (
  input  logic        clk,
  input  logic        reset,
  mips_exec_if.slave  bus
);

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,  OP_SUB  = 5'd1,  OP_AND  = 5'd2,  OP_OR    = 5'd3,
    OP_XOR   = 5'd4,  OP_SLT  = 5'd5,  OP_SLTU = 5'd6,  OP_SLL   = 5'd7,
    OP_SRL   = 5'd8,  OP_SRA  = 5'd9,  OP_SLLV = 5'd10, OP_SRLV  = 5'd11,
    OP_SRAV  = 5'd12, OP_MULT = 5'd13, OP_MULTU = 5'd14, OP_DIV  = 5'd15,
    OP_DIVU  = 5'd16, OP_LUI  = 5'd17
  } alu_op_e;

  alu_op_e     alu_ctrl_s;
  logic [31:0] alu_res_s;
  logic [31:0] hi_s;
  logic [31:0] lo_s;
  logic [63:0] prod_signed_s;
  logic [63:0] prod_unsigned_s;
  logic [31:0] abs_a_s;
  logic [31:0] abs_b_s;
  logic [31:0] dividend_s;
  logic [31:0] divisor_s;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [31:0] tgt_sel_s;
  logic [31:0] tgt_r;

  // ALU control decode from alu_op, function code and opcode
  always_comb begin
    alu_ctrl_s = OP_ADD;
    case (bus.alu_op)
      2'b00: alu_ctrl_s = OP_ADD;
      2'b01: alu_ctrl_s = OP_SUB;
      2'b10: begin
        case (bus.function_code)
          6'h21:   alu_ctrl_s = OP_ADD;
          6'h23:   alu_ctrl_s = OP_SUB;
          6'h24:   alu_ctrl_s = OP_AND;
          6'h25:   alu_ctrl_s = OP_OR;
          6'h26:   alu_ctrl_s = OP_XOR;
          6'h2A:   alu_ctrl_s = OP_SLT;
          6'h2B:   alu_ctrl_s = OP_SLTU;
          6'h00:   alu_ctrl_s = OP_SLL;
          6'h02:   alu_ctrl_s = OP_SRL;
          6'h03:   alu_ctrl_s = OP_SRA;
          6'h04:   alu_ctrl_s = OP_SLLV;
          6'h06:   alu_ctrl_s = OP_SRLV;
          6'h07:   alu_ctrl_s = OP_SRAV;
          6'h18:   alu_ctrl_s = OP_MULT;
          6'h19:   alu_ctrl_s = OP_MULTU;
          6'h1A:   alu_ctrl_s = OP_DIV;
          6'h1B:   alu_ctrl_s = OP_DIVU;
          default: alu_ctrl_s = OP_ADD;
        endcase
      end
      2'b11: begin
        case (bus.opcode)
          6'h09:   alu_ctrl_s = OP_ADD;
          6'h0A:   alu_ctrl_s = OP_SLT;
          6'h0B:   alu_ctrl_s = OP_SLTU;
          6'h0C:   alu_ctrl_s = OP_AND;
          6'h0D:   alu_ctrl_s = OP_OR;
          6'h0E:   alu_ctrl_s = OP_XOR;
          6'h0F:   alu_ctrl_s = OP_LUI;
          default: alu_ctrl_s = OP_ADD;
        endcase
      end
      default: alu_ctrl_s = OP_ADD;
    endcase
  end

  // Signed product of sign-extended operands is exact in the low 64 bits
  assign prod_signed_s   = {{32{bus.a[31]}}, bus.a} * {{32{bus.b[31]}}, bus.b};
  assign prod_unsigned_s = {32'h0000_0000, bus.a} * {32'h0000_0000, bus.b};

  assign abs_a_s = bus.a[31] ? (32'h0000_0000 - bus.a) : bus.a;
  assign abs_b_s = bus.b[31] ? (32'h0000_0000 - bus.b) : bus.b;

  // One unsigned divider serves both DIV (on magnitudes) and DIVU
  always_comb begin
    if (alu_ctrl_s == OP_DIV) begin
      dividend_s = abs_a_s;
      divisor_s  = abs_b_s;
    end else begin
      dividend_s = bus.a;
      divisor_s  = bus.b;
    end
  end

  // Guarded division; a zero divisor yields zero quotient and remainder
  always_comb begin
    if (divisor_s == 32'h0000_0000) begin
      quo_s = 32'h0000_0000;
      rem_s = 32'h0000_0000;
    end else begin
      quo_s = dividend_s / divisor_s;
      rem_s = dividend_s % divisor_s;
    end
  end

  // ALU result and hi/lo selection
  always_comb begin
    alu_res_s = 32'h0000_0000;
    hi_s      = 32'h0000_0000;
    lo_s      = 32'h0000_0000;
    case (alu_ctrl_s)
      OP_ADD:   alu_res_s = bus.a + bus.b;
      OP_SUB:   alu_res_s = bus.a - bus.b;
      OP_AND:   alu_res_s = bus.a & bus.b;
      OP_OR:    alu_res_s = bus.a | bus.b;
      OP_XOR:   alu_res_s = bus.a ^ bus.b;
      OP_SLT:   alu_res_s = ($signed(bus.a) < $signed(bus.b)) ? 32'h0000_0001 : 32'h0000_0000;
      OP_SLTU:  alu_res_s = (bus.a < bus.b) ? 32'h0000_0001 : 32'h0000_0000;
      OP_SLL:   alu_res_s = bus.b << bus.shamt;
      OP_SRL:   alu_res_s = bus.b >> bus.shamt;
      OP_SRA:   alu_res_s = $unsigned($signed(bus.b) >>> bus.shamt);
      OP_SLLV:  alu_res_s = bus.b << bus.a[4:0];
      OP_SRLV:  alu_res_s = bus.b >> bus.a[4:0];
      OP_SRAV:  alu_res_s = $unsigned($signed(bus.b) >>> bus.a[4:0]);
      OP_MULT:  {hi_s, lo_s} = prod_signed_s;
      OP_MULTU: {hi_s, lo_s} = prod_unsigned_s;
      OP_DIV: begin
        lo_s = (bus.a[31] ^ bus.b[31]) ? (32'h0000_0000 - quo_s) : quo_s;
        hi_s = bus.a[31] ? (32'h0000_0000 - rem_s) : rem_s;
      end
      OP_DIVU: begin
        lo_s = quo_s;
        hi_s = rem_s;
      end
      OP_LUI:   alu_res_s = {bus.b[15:0], 16'h0000};
      default:  alu_res_s = 32'h0000_0000;
    endcase
  end

  // Next-PC target priority: register jump, absolute jump, branch, sequential
  always_comb begin
    if (bus.jump2) begin
      tgt_sel_s = bus.a;
    end else if (bus.jump1) begin
      tgt_sel_s = bus.jump_addr;
    end else if (bus.condition_met) begin
      tgt_sel_s = bus.branch_addr;
    end else begin
      tgt_sel_s = bus.pc_plus4;
    end
  end

  // Delay-slot target register, loaded during EXEC
  always_ff @(posedge clk) begin
    if (reset) begin
      tgt_r <= 32'h0000_0000;
    end else if (bus.clk_enable) begin
      tgt_r <= tgt_sel_s;
    end
  end

  assign bus.alu_ctrl   = alu_ctrl_s;
  assign bus.alu_out    = alu_res_s;
  assign bus.zero       = (alu_res_s == 32'h0000_0000);
  assign bus.hi         = hi_s;
  assign bus.lo         = lo_s;
  assign bus.tgt_addr_0 = tgt_sel_s;
  assign bus.tgt_addr_1 = tgt_r;

endmodule

// File: tb/tb_mips_exec_unit.sv
// Directed self-checking bench for mips_exec_unit.
module tb_mips_exec_unit;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mips_exec_if bus ();

  mips_exec_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.clk_enable    = 1'b0;
    bus.alu_op        = 2'b00;
    bus.opcode        = 6'h00;
    bus.function_code = 6'h00;
    bus.shamt         = 5'd0;
    bus.a             = 32'h0;
    bus.b             = 32'h0;
    bus.branch_addr   = 32'h0;
    bus.jump_addr     = 32'h0;
    bus.pc_plus4      = 32'h0;
    bus.condition_met = 1'b0;
    bus.jump1         = 1'b0;
    bus.jump2         = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.clk_enable = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.tgt_addr_1 !== 32'h0) begin
      errors++; $display("FAIL reset_tgt: got %h expected %h", bus.tgt_addr_1, 32'h0);
    end
    reset = 1'b0;
  endtask

  task automatic test_add_sub();
    bus.alu_op = 2'b10; bus.function_code = 6'h21; bus.a = 32'h7FFF_FFFF; bus.b = 32'h1; #1;
    checks++;
    if (bus.alu_ctrl !== 5'd0) begin errors++; $display("FAIL add_ctrl: got %0d expected 0", bus.alu_ctrl); end
    checks++;
    if (bus.alu_out !== 32'h8000_0000) begin errors++; $display("FAIL add_wrap: got %h expected 80000000", bus.alu_out); end
    checks++;
    if (bus.zero !== 1'b0) begin errors++; $display("FAIL add_zero: got %b expected 0", bus.zero); end
    bus.function_code = 6'h23; bus.a = 32'h5; bus.b = 32'h5; #1;
    checks++;
    if (bus.alu_ctrl !== 5'd1 || bus.alu_out !== 32'h0 || bus.zero !== 1'b1) begin
      errors++; $display("FAIL sub_eq: got ctrl %0d out %h zero %b expected 1 0 1", bus.alu_ctrl, bus.alu_out, bus.zero);
    end
    bus.alu_op = 2'b01; bus.a = 32'h3; bus.b = 32'h5; #1;
    checks++;
    if (bus.alu_ctrl !== 5'd1 || bus.alu_out !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL aluop01_sub: got ctrl %0d out %h expected 1 fffffffe", bus.alu_ctrl, bus.alu_out);
    end
    bus.alu_op = 2'b10; bus.function_code = 6'h3F; #1;
    checks++;
    if (bus.alu_ctrl !== 5'd0 || bus.alu_out !== 32'h8) begin
      errors++; $display("FAIL funct_default: got ctrl %0d out %h expected 0 8", bus.alu_ctrl, bus.alu_out);
    end
  endtask

  task automatic test_logic_shift();
    bus.alu_op = 2'b10; bus.function_code = 6'h03; bus.shamt = 5'd4; bus.b = 32'hF000_0000; #1;
    checks++;
    if (bus.alu_ctrl !== 5'd9 || bus.alu_out !== 32'hFF00_0000) begin
      errors++; $display("FAIL sra: got ctrl %0d out %h expected 9 ff000000", bus.alu_ctrl, bus.alu_out);
    end
    bus.function_code = 6'h02; #1;
    checks++;
    if (bus.alu_out !== 32'h0F00_0000) begin errors++; $display("FAIL srl: got %h expected 0f000000", bus.alu_out); end
    bus.function_code = 6'h06; bus.a = 32'h24; bus.b = 32'h8000_0000; #1;
    checks++;
    if (bus.alu_ctrl !== 5'd11 || bus.alu_out !== 32'h0800_0000) begin
      errors++; $display("FAIL srlv: got ctrl %0d out %h expected 11 08000000", bus.alu_ctrl, bus.alu_out);
    end
    bus.function_code = 6'h07; #1;
    checks++;
    if (bus.alu_out !== 32'hF800_0000) begin errors++; $display("FAIL srav: got %h expected f8000000", bus.alu_out); end
    bus.function_code = 6'h26; bus.a = 32'hFF00_FF00; bus.b = 32'h0FF0_0FF0; #1;
    checks++;
    if (bus.alu_out !== 32'hF0F0_F0F0) begin errors++; $display("FAIL xor: got %h expected f0f0f0f0", bus.alu_out); end
  endtask

  task automatic test_itype();
    bus.alu_op = 2'b11; bus.opcode = 6'h0F; bus.b = 32'h0000_1234; #1;
    checks++;
    if (bus.alu_ctrl !== 5'd17 || bus.alu_out !== 32'h1234_0000) begin
      errors++; $display("FAIL lui: got ctrl %0d out %h expected 17 12340000", bus.alu_ctrl, bus.alu_out);
    end
    bus.opcode = 6'h0A; bus.a = 32'hFFFF_FFFF; bus.b = 32'h1; #1;
    checks++;
    if (bus.alu_out !== 32'h1) begin errors++; $display("FAIL slt: got %h expected 1", bus.alu_out); end
    bus.opcode = 6'h0B; #1;
    checks++;
    if (bus.alu_out !== 32'h0 || bus.zero !== 1'b1) begin
      errors++; $display("FAIL sltu: got out %h zero %b expected 0 1", bus.alu_out, bus.zero);
    end
    bus.opcode = 6'h0D; bus.a = 32'h00F0; bus.b = 32'h0F00; #1;
    checks++;
    if (bus.alu_ctrl !== 5'd3 || bus.alu_out !== 32'h0FF0) begin
      errors++; $display("FAIL ori: got ctrl %0d out %h expected 3 00000ff0", bus.alu_ctrl, bus.alu_out);
    end
    checks++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      errors++; $display("FAIL hilo_idle: got hi %h lo %h expected 0 0", bus.hi, bus.lo);
    end
  endtask

  task automatic test_muldiv();
    bus.alu_op = 2'b10; bus.function_code = 6'h18; bus.a = 32'hFFFF_FFFE; bus.b = 32'h3; #1;
    checks++;
    if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFA || bus.alu_out !== 32'h0) begin
      errors++; $display("FAIL mult: got hi %h lo %h out %h expected ffffffff fffffffa 0", bus.hi, bus.lo, bus.alu_out);
    end
    bus.function_code = 6'h19; #1;
    checks++;
    if (bus.hi !== 32'h2 || bus.lo !== 32'hFFFF_FFFA) begin
      errors++; $display("FAIL multu: got hi %h lo %h expected 2 fffffffa", bus.hi, bus.lo);
    end
    bus.function_code = 6'h1A; bus.a = 32'hFFFF_FFF9; bus.b = 32'h2; #1;
    checks++;
    if (bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL div_neg: got lo %h hi %h expected fffffffd ffffffff", bus.lo, bus.hi);
    end
    bus.a = 32'h8000_0000; bus.b = 32'hFFFF_FFFF; #1;
    checks++;
    if (bus.lo !== 32'h8000_0000 || bus.hi !== 32'h0) begin
      errors++; $display("FAIL div_ovf: got lo %h hi %h expected 80000000 0", bus.lo, bus.hi);
    end
    bus.function_code = 6'h1B; bus.a = 32'h1234; bus.b = 32'h0; #1;
    checks++;
    if (bus.lo !== 32'h0 || bus.hi !== 32'h0) begin
      errors++; $display("FAIL divu_zero: got lo %h hi %h expected 0 0", bus.lo, bus.hi);
    end
    bus.a = 32'hFFFF_FFF9; bus.b = 32'h2; #1;
    checks++;
    if (bus.lo !== 32'h7FFF_FFFC || bus.hi !== 32'h1) begin
      errors++; $display("FAIL divu: got lo %h hi %h expected 7ffffffc 1", bus.lo, bus.hi);
    end
  endtask

  task automatic test_target();
    bus.pc_plus4 = 32'h104; bus.branch_addr = 32'h200; bus.jump_addr = 32'h300; bus.a = 32'h400;
    bus.condition_met = 1'b0; bus.jump1 = 1'b0; bus.jump2 = 1'b0; #1;
    checks++;
    if (bus.tgt_addr_0 !== 32'h104) begin errors++; $display("FAIL tgt_seq: got %h expected 104", bus.tgt_addr_0); end
    bus.condition_met = 1'b1; #1;
    checks++;
    if (bus.tgt_addr_0 !== 32'h200) begin errors++; $display("FAIL tgt_branch: got %h expected 200", bus.tgt_addr_0); end
    bus.jump1 = 1'b1; #1;
    checks++;
    if (bus.tgt_addr_0 !== 32'h300) begin errors++; $display("FAIL tgt_jump: got %h expected 300", bus.tgt_addr_0); end
    bus.jump2 = 1'b1; #1;
    checks++;
    if (bus.tgt_addr_0 !== 32'h400) begin errors++; $display("FAIL tgt_jr: got %h expected 400", bus.tgt_addr_0); end
  endtask

  task automatic test_register();
    bus.jump2 = 1'b0; bus.jump1 = 1'b0; bus.condition_met = 1'b0; bus.clk_enable = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.tgt_addr_1 !== 32'h104) begin errors++; $display("FAIL reg_load: got %h expected 104", bus.tgt_addr_1); end
    bus.clk_enable = 1'b0; bus.condition_met = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.tgt_addr_1 !== 32'h104) begin errors++; $display("FAIL reg_hold: got %h expected 104", bus.tgt_addr_1); end
    bus.clk_enable = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.tgt_addr_1 !== 32'h200) begin errors++; $display("FAIL reg_load2: got %h expected 200", bus.tgt_addr_1); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.tgt_addr_1 !== 32'h0) begin errors++; $display("FAIL reg_reset_en: got %h expected 0", bus.tgt_addr_1); end
    reset = 1'b0; bus.clk_enable = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    clear_inputs();
    #2;
    test_reset();
    test_add_sub();
    test_logic_shift();
    test_itype();
    test_muldiv();
    test_target();
    test_register();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
